// File: rtl/pa_defs.sv
// rtl/pa_defs.sv - shared widths, sync marker and loader state encoding
// Purpose: common definitions for the bundle loader and its assembler.
// Ports: none (package).
package pa_defs;

    localparam int ADDR_W   = 16;
    localparam int BUNDLE_W = 60;
    localparam int WORD_W   = 16;
    localparam int INSTR_W  = 30;

    localparam logic [15:0] SYNC_WORD = 16'hA55A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BASE,
        ST_COUNT,
        ST_PAYLOAD,
        ST_WRITE,
        ST_CSUM
    } loaderState_t;

endpackage

// File: rtl/bundle_assembler.sv
// rtl/bundle_assembler.sv - packs four payload words into one bundle and keeps the running XOR
// Purpose: shift register + 2-bit word index + XOR accumulator driven by the loader FSM.
// Ports:
//   clock_i, reset_i    clock, asynchronous active-high reset
//   clear_i             zero the word index and XOR accumulator (start of a packet)
//   shift_i             take word_i: shift into bundle, XOR into checksum, index++
//   word_i              incoming payload word
//   bundle_o            bundle register contents
//   nextBundle_o        bundle as it will be once word_i is shifted in
//   index_o             payload word position within the current bundle
//   xorAcc_o            XOR of every payload word taken since the last clear
module bundle_assembler
    import pa_defs::*;
#(
    parameter int WW = 16,
    parameter int BW = 60
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          clear_i,
    input  logic          shift_i,
    input  logic [WW-1:0] word_i,
    output logic [BW-1:0] bundle_o,
    output logic [BW-1:0] nextBundle_o,
    output logic [1:0]    index_o,
    output logic [WW-1:0] xorAcc_o
);

    // Shifting a 60-bit register left by a full word drops the top nibble of
    // the first word, which is exactly the ignored word[15:12] of slot 0.
    assign nextBundle_o = {bundle_o[BW-WW-1:0], word_i};

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            bundle_o <= '0;
            index_o  <= '0;
            xorAcc_o <= '0;
        end else if (clear_i) begin
            index_o  <= '0;
            xorAcc_o <= '0;
        end else if (shift_i) begin
            bundle_o <= nextBundle_o;
            index_o  <= index_o + 2'd1;
            xorAcc_o <= xorAcc_o ^ word_i;
        end
    end

endmodule

// File: rtl/bundle_loader.sv
// rtl/bundle_loader.sv - writes 60-bit VLIW-2 bundles from a word stream into instruction memory
// Purpose: parses SYNC/BASE/COUNT/payload/CHECKSUM packets, writes one bundle per four
//          payload words and keeps the core held until a load ends with a good checksum.
// Ports:
//   clock_i, reset_i               clock, asynchronous active-high reset
//   wordValid_i, word_i            incoming stream word
//   wordReady_o                    loader accepts a word this cycle
//   imemWe_o, imemAddr_o, imemData_o  one-cycle I-mem write port
//   coreHold_o                     core held while the program is not valid
//   loadDone_o                     one-cycle pulse at the end of a packet
//   loadError_o                    sticky checksum-mismatch flag of the last packet
module bundle_loader #(
    parameter int ADDR_W   = pa_defs::ADDR_W,
    parameter int BUNDLE_W = pa_defs::BUNDLE_W,
    parameter int WORD_W   = pa_defs::WORD_W,
    parameter logic [15:0] SYNC_WORD = pa_defs::SYNC_WORD
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                wordValid_i,
    input  logic [WORD_W-1:0]   word_i,
    output logic                wordReady_o,
    output logic                imemWe_o,
    output logic [ADDR_W-1:0]   imemAddr_o,
    output logic [BUNDLE_W-1:0] imemData_o,
    output logic                coreHold_o,
    output logic                loadDone_o,
    output logic                loadError_o
);
    import pa_defs::*;

    loaderState_t        state, stateNext;
    logic [ADDR_W-1:0]   addr, addrNext;
    logic [WORD_W-1:0]   remaining, remNext;
    logic                weNext, holdNext, errNext, doneNext;
    logic [ADDR_W-1:0]   imemAddrNext;
    logic [BUNDLE_W-1:0] dataNext;
    logic                asmClear, asmShift;
    logic [BUNDLE_W-1:0] bundle, nextBundle;
    logic [1:0]          index;
    logic [WORD_W-1:0]   xorAcc;
    logic                accept;

    assign accept = wordValid_i & wordReady_o;

    bundle_assembler #(.WW(WORD_W), .BW(BUNDLE_W)) assembler (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .clear_i      (asmClear),
        .shift_i      (asmShift),
        .word_i       (word_i),
        .bundle_o     (bundle),
        .nextBundle_o (nextBundle),
        .index_o      (index),
        .xorAcc_o     (xorAcc)
    );

    always_comb begin
        stateNext    = state;
        addrNext     = addr;
        remNext      = remaining;
        weNext       = 1'b0;
        imemAddrNext = imemAddr_o;
        dataNext     = imemData_o;
        holdNext     = coreHold_o;
        errNext      = loadError_o;
        doneNext     = 1'b0;
        asmClear     = 1'b0;
        asmShift     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && word_i == SYNC_WORD) begin
                    stateNext = ST_BASE;
                    holdNext  = 1'b1;
                    errNext   = 1'b0;
                end
            end
            ST_BASE: begin
                if (accept) begin
                    addrNext  = word_i[ADDR_W-1:0];
                    stateNext = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (accept) begin
                    remNext   = word_i;
                    asmClear  = 1'b1;
                    stateNext = (word_i == '0) ? ST_CSUM : ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    asmShift = 1'b1;
                    // Launch the write on the 4th word so the strobe is high
                    // during the single WRITE cycle.
                    if (index == 2'd3) begin
                        stateNext    = ST_WRITE;
                        weNext       = 1'b1;
                        imemAddrNext = addr;
                        dataNext     = nextBundle;
                    end
                end
            end
            ST_WRITE: begin
                addrNext  = addr + 1'b1;
                remNext   = remaining - 1'b1;
                stateNext = (remaining == 1) ? ST_CSUM : ST_PAYLOAD;
            end
            ST_CSUM: begin
                if (accept) begin
                    doneNext  = 1'b1;
                    holdNext  = (xorAcc != word_i);
                    errNext   = (xorAcc != word_i);
                    stateNext = ST_IDLE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= ST_IDLE;
            addr        <= '0;
            remaining   <= '0;
            wordReady_o <= 1'b0;
            imemWe_o    <= 1'b0;
            imemAddr_o  <= '0;
            imemData_o  <= '0;
            coreHold_o  <= 1'b1;
            loadDone_o  <= 1'b0;
            loadError_o <= 1'b0;
        end else begin
            state       <= stateNext;
            addr        <= addrNext;
            remaining   <= remNext;
            wordReady_o <= (stateNext != ST_WRITE);
            imemWe_o    <= weNext;
            imemAddr_o  <= imemAddrNext;
            imemData_o  <= dataNext;
            coreHold_o  <= holdNext;
            loadDone_o  <= doneNext;
            loadError_o <= errNext;
        end
    end

endmodule

// File: tb/tb_bundle_loader.sv
// tb/tb_bundle_loader.sv - scoreboard bench for bundle_loader
module tb_bundle_loader;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        wordValid_i = 1'b0;
    logic [15:0] word_i = 16'h0;
    logic        wordReady_o, imemWe_o, coreHold_o, loadDone_o, loadError_o;
    logic [15:0] imemAddr_o;
    logic [59:0] imemData_o;

    bundle_loader dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .wordValid_i (wordValid_i),
        .word_i      (word_i),
        .wordReady_o (wordReady_o),
        .imemWe_o    (imemWe_o),
        .imemAddr_o  (imemAddr_o),
        .imemData_o  (imemData_o),
        .coreHold_o  (coreHold_o),
        .loadDone_o  (loadDone_o),
        .loadError_o (loadError_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct { logic [15:0] addr; logic [59:0] data; } wr_t;
    typedef struct { logic err; } dn_t;
    wr_t wrQ[$];
    dn_t dnQ[$];

    int nChecks = 0;
    int nPass   = 0;
    logic prevWe   = 1'b0;
    logic prevDone = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // Monitor: compares every write strobe and done pulse against the queues.
    always @(negedge clock_i) begin
        if (reset_i) begin
            prevWe   <= 1'b0;
            prevDone <= 1'b0;
        end else begin
            if (prevWe) check("readyAfterWrite", 64'(wordReady_o), 64'd1);
            if (imemWe_o) begin
                check("readyLowInWrite", 64'(wordReady_o), 64'd0);
                check("holdDuringLoad", 64'(coreHold_o), 64'd1);
                check("weSinglePulse", 64'(prevWe), 64'd0);
                if (wrQ.size() == 0) begin
                    check("unexpectedWrite", 64'(wrQ.size()), 64'd1);
                end else begin
                    wr_t e;
                    e = wrQ.pop_front();
                    check("writeAddr", 64'(imemAddr_o), 64'(e.addr));
                    check("writeData", 64'(imemData_o), 64'(e.data));
                end
            end
            if (loadDone_o) begin
                check("doneSinglePulse", 64'(prevDone), 64'd0);
                check("writesBeforeDone", 64'(wrQ.size()), 64'd0);
                if (dnQ.size() == 0) begin
                    check("unexpectedDone", 64'(dnQ.size()), 64'd1);
                end else begin
                    dn_t d;
                    d = dnQ.pop_front();
                    check("loadError", 64'(loadError_o), 64'(d.err));
                    check("coreHold", 64'(coreHold_o), 64'(d.err));
                end
            end
            prevWe   <= imemWe_o;
            prevDone <= loadDone_o;
        end
    end

    task automatic sendWord(input logic [15:0] w, input int gapMax);
        int tries;
        repeat ($urandom_range(0, gapMax)) begin
            @(negedge clock_i);
            wordValid_i = 1'b0;
        end
        @(negedge clock_i);
        wordValid_i = 1'b1;
        word_i      = w;
        tries       = 0;
        while (!wordReady_o && tries < 100) begin
            @(negedge clock_i);
            tries++;
        end
        if (tries >= 100) check("readyTimeout", 64'(tries), 64'd0);
        @(posedge clock_i);
    endtask

    task automatic idleBus();
        @(negedge clock_i);
        wordValid_i = 1'b0;
    endtask

    // Reference model: bundle k of the packet lands at (base+k) mod 2^16 and is
    // {w0[11:0], w1, w2, w3}; the checksum is the XOR of all payload words.
    task automatic sendPacket(input logic [15:0] base, input logic [15:0] pl[$],
                              input logic [15:0] csumDelta, input int gapMax);
        logic [15:0] xr;
        wr_t         e;
        dn_t         d;
        int          nb;
        xr = 16'h0;
        nb = pl.size() / 4;
        for (int b = 0; b < nb; b++) begin
            e.addr = 16'(base + b);
            e.data = {pl[4*b][11:0], pl[4*b+1], pl[4*b+2], pl[4*b+3]};
            wrQ.push_back(e);
        end
        foreach (pl[i]) xr = xr ^ pl[i];
        d.err = (csumDelta != 16'h0);
        dnQ.push_back(d);
        sendWord(16'hA55A, gapMax);
        sendWord(base, gapMax);
        sendWord(16'(nb), gapMax);
        foreach (pl[i]) sendWord(pl[i], gapMax);
        sendWord(16'(xr + csumDelta), gapMax);
        idleBus();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((wrQ.size() != 0 || dnQ.size() != 0) && n < 200) begin
            @(negedge clock_i);
            n++;
        end
        @(negedge clock_i);
        check("drainPending", 64'(wrQ.size() + dnQ.size()), 64'd0);
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, "_ready"}, 64'(wordReady_o), 64'd0);
        check({tag, "_we"},    64'(imemWe_o),    64'd0);
        check({tag, "_addr"},  64'(imemAddr_o),  64'd0);
        check({tag, "_data"},  64'(imemData_o),  64'd0);
        check({tag, "_hold"},  64'(coreHold_o),  64'd1);
        check({tag, "_done"},  64'(loadDone_o),  64'd0);
        check({tag, "_err"},   64'(loadError_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pl[$];
        logic [15:0] plA[$];

        repeat (3) @(posedge clock_i);
        @(negedge clock_i);
        checkResetValues("reset");
        reset_i = 1'b0;

        // Directed load: one bundle, good checksum.
        plA = '{16'h0ABC, 16'h1234, 16'h5678, 16'h9ABC};
        sendPacket(16'h0010, plA, 16'h0000, 0);
        drain();
        check("holdReleased", 64'(coreHold_o), 64'd0);

        // Same packet with checksum + 1.
        sendPacket(16'h0010, plA, 16'h0001, 0);
        drain();

        // Address wrap: two bundles starting at FFFF.
        pl = {};
        for (int i = 0; i < 8; i++) pl.push_back(16'($urandom));
        sendPacket(16'hFFFF, pl, 16'h0000, 0);
        drain();

        // Garbage before sync, then an empty packet.
        sendWord(16'h1234, 0);
        sendWord(16'hA55B, 0);
        pl = {};
        sendPacket(16'h0200, pl, 16'h0000, 0);
        drain();
        check("emptyLoadHold", 64'(coreHold_o), 64'd0);

        // Randomised packets with valid gaps and occasional bad checksums.
        for (int p = 0; p < 6; p++) begin
            int nb;
            nb = $urandom_range(1, 3);
            pl = {};
            for (int i = 0; i < 4 * nb; i++) pl.push_back(16'($urandom));
            sendPacket(16'($urandom), pl,
                       ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0000, 3);
            drain();
        end

        // Reset mid-payload: asynchronous, partial bundle must never be written.
        sendWord(16'hA55A, 1);
        sendWord(16'h0300, 1);
        sendWord(16'h0002, 1);
        sendWord(16'h1111, 1);
        sendWord(16'h2222, 1);
        idleBus();
        @(posedge clock_i);
        #2 reset_i = 1'b1;
        #1 checkResetValues("midReset");
        @(negedge clock_i);
        reset_i = 1'b0;

        pl = {};
        for (int i = 0; i < 8; i++) pl.push_back(16'($urandom));
        sendPacket(16'h0400, pl, 16'h0000, 2);
        drain();
        check("finalHold", 64'(coreHold_o), 64'd0);
        check("finalError", 64'(loadError_o), 64'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
